// File: rtl/pin_access_pkg.sv
// rtl/pin_access_pkg.sv - shared state, message codes and sizing helper for the PIN access controller
package pin_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_PIN = 2'd1,
        ST_GRANTED  = 2'd2,
        ST_LOCKED   = 2'd3
    } state_t;

    localparam logic [3:0] MSG_IDLE    = 4'b0000;
    localparam logic [3:0] MSG_ENTER   = 4'b0001;
    localparam logic [3:0] MSG_WRONG   = 4'b0010;
    localparam logic [3:0] MSG_LOCKED  = 4'b1000;
    localparam logic [3:0] MSG_WELCOME = 4'b1111;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pin_access_controller_if.sv
// rtl/pin_access_controller_if.sv - keypad/session request side and status side of the controller
interface pin_access_controller_if #(
    parameter int PIN_WIDTH = 4,
    parameter int MAX_TRIES = 3
);
    localparam int FC_W = $clog2(MAX_TRIES + 1);

    logic                 HasAccess;
    logic                 pin_valid;
    logic [PIN_WIDTH-1:0] Input_Pin;
    logic                 pin_ready;
    logic [3:0]           message;
    logic                 Welcome;
    logic                 locked;
    logic [FC_W-1:0]      fail_count;

    modport master (
        output HasAccess, pin_valid, Input_Pin,
        input  pin_ready, message, Welcome, locked, fail_count
    );

    modport slave (
        input  HasAccess, pin_valid, Input_Pin,
        output pin_ready, message, Welcome, locked, fail_count
    );

endinterface

// File: rtl/access_timer.sv
// rtl/access_timer.sv - loadable down-counter; a load of K pulses expired in the K-th following cycle
module access_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = !load && (count == WIDTH'(1));

endmodule

// File: rtl/pin_access_controller.sv
// rtl/pin_access_controller.sv - session FSM, failure counter and registered status outputs
module pin_access_controller
    import pin_access_pkg::*;
#(
    parameter int                   PIN_WIDTH      = 4,
    parameter logic [PIN_WIDTH-1:0] STORED_PIN     = 4'b1111,
    parameter int                   MAX_TRIES      = 3,
    parameter int                   GRANT_CYCLES   = 8,
    parameter int                   LOCK_CYCLES    = 16,
    parameter int                   TIMEOUT_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pin_access_controller_if.slave bus
);

    localparam int FC_W  = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(max3(GRANT_CYCLES, LOCK_CYCLES, TIMEOUT_CYCLES)) + 1;

    state_t          state, state_nx;
    logic [FC_W-1:0] fail_q, fail_nx, fail_inc;
    logic            wrong_q, wrong_nx;
    logic            match, will_lock;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expired;

    logic       ready_q, welcome_q, locked_q;
    logic [3:0] msg_q, msg_nx;

    assign match     = (bus.Input_Pin == STORED_PIN);
    assign fail_inc  = (fail_q == FC_W'(MAX_TRIES)) ? fail_q : fail_q + 1'b1;
    assign will_lock = (fail_inc == FC_W'(MAX_TRIES));

    // Kept apart from the next-state block so the load never depends on tmr_expired.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (bus.HasAccess) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT_CYCLES);
                end
            end
            ST_WAIT_PIN: begin
                if (bus.HasAccess && bus.pin_valid) begin
                    tmr_load = 1'b1;
                    if (match)          tmr_val = TMR_W'(GRANT_CYCLES);
                    else if (will_lock) tmr_val = TMR_W'(LOCK_CYCLES);
                    else                tmr_val = TMR_W'(TIMEOUT_CYCLES);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        fail_nx  = fail_q;
        wrong_nx = wrong_q;
        case (state)
            ST_IDLE: begin
                if (bus.HasAccess) begin
                    state_nx = ST_WAIT_PIN;
                    wrong_nx = 1'b0;
                end
            end
            ST_WAIT_PIN: begin
                if (!bus.HasAccess) begin
                    state_nx = ST_IDLE;
                end else if (bus.pin_valid) begin
                    if (match) begin
                        state_nx = ST_GRANTED;
                        fail_nx  = '0;
                    end else begin
                        fail_nx  = fail_inc;
                        wrong_nx = 1'b1;
                        if (will_lock) state_nx = ST_LOCKED;
                    end
                end else if (tmr_expired) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_GRANTED: begin
                if (!bus.HasAccess || tmr_expired) state_nx = ST_IDLE;
            end
            ST_LOCKED: begin
                if (tmr_expired) begin
                    state_nx = ST_IDLE;
                    fail_nx  = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        msg_nx = MSG_IDLE;
        case (state_nx)
            ST_WAIT_PIN: msg_nx = wrong_nx ? MSG_WRONG : MSG_ENTER;
            ST_GRANTED:  msg_nx = MSG_WELCOME;
            ST_LOCKED:   msg_nx = MSG_LOCKED;
            default:     msg_nx = MSG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            fail_q    <= '0;
            wrong_q   <= 1'b0;
            ready_q   <= 1'b0;
            welcome_q <= 1'b0;
            locked_q  <= 1'b0;
            msg_q     <= MSG_IDLE;
        end else begin
            state     <= state_nx;
            fail_q    <= fail_nx;
            wrong_q   <= wrong_nx;
            ready_q   <= (state_nx == ST_WAIT_PIN);
            welcome_q <= (state_nx == ST_GRANTED);
            locked_q  <= (state_nx == ST_LOCKED);
            msg_q     <= msg_nx;
        end
    end

    access_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    assign bus.pin_ready  = ready_q;
    assign bus.message    = msg_q;
    assign bus.Welcome    = welcome_q;
    assign bus.locked     = locked_q;
    assign bus.fail_count = fail_q;

endmodule

// File: tb/tb_pin_access_controller.sv
// tb/tb_pin_access_controller.sv - scoreboard bench: directed scenarios then random traffic against a session model
module tb_pin_access_controller;

    localparam int         PIN_W   = 4;
    localparam logic [3:0] PIN_OK  = 4'b1111;
    localparam int         TRIES   = 3;
    localparam int         GRANT_N = 8;
    localparam int         LOCK_N  = 16;
    localparam int         TOUT_N  = 32;

    localparam int P_IDLE  = 0;
    localparam int P_ENTRY = 1;
    localparam int P_GRANT = 2;
    localparam int P_LOCK  = 3;

    typedef struct packed {
        logic       ready;
        logic [3:0] msg;
        logic       welcome;
        logic       locked;
        logic [1:0] fails;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pin_access_controller_if #(.PIN_WIDTH(PIN_W), .MAX_TRIES(TRIES)) bus ();

    pin_access_controller #(
        .PIN_WIDTH      (PIN_W),
        .STORED_PIN     (PIN_OK),
        .MAX_TRIES      (TRIES),
        .GRANT_CYCLES   (GRANT_N),
        .LOCK_CYCLES    (LOCK_N),
        .TIMEOUT_CYCLES (TOUT_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Session model: phase plus cycles left in the timed phase.
    int m_phase = P_IDLE;
    int m_left  = 0;
    int m_fails = 0;
    bit m_wrong = 1'b0;

    function automatic obs_t model_view();
        obs_t o;
        o.ready   = (m_phase == P_ENTRY);
        o.welcome = (m_phase == P_GRANT);
        o.locked  = (m_phase == P_LOCK);
        o.fails   = 2'(m_fails);
        case (m_phase)
            P_ENTRY: o.msg = m_wrong ? 4'b0010 : 4'b0001;
            P_GRANT: o.msg = 4'b1111;
            P_LOCK:  o.msg = 4'b1000;
            default: o.msg = 4'b0000;
        endcase
        return o;
    endfunction

    task automatic model_step(input bit r, input bit ha, input bit pv, input logic [3:0] pin);
        if (r) begin
            m_phase = P_IDLE; m_left = 0; m_fails = 0; m_wrong = 1'b0;
            return;
        end
        case (m_phase)
            P_IDLE: if (ha) begin
                m_phase = P_ENTRY; m_left = TOUT_N; m_wrong = 1'b0;
            end
            P_ENTRY: begin
                if (!ha) begin
                    m_phase = P_IDLE;
                end else if (pv && pin == PIN_OK) begin
                    m_phase = P_GRANT; m_left = GRANT_N; m_fails = 0;
                end else if (pv) begin
                    m_fails = (m_fails < TRIES) ? m_fails + 1 : TRIES;
                    m_wrong = 1'b1;
                    if (m_fails == TRIES) begin
                        m_phase = P_LOCK; m_left = LOCK_N;
                    end else begin
                        m_left = TOUT_N;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) m_phase = P_IDLE;
                end
            end
            P_GRANT: begin
                m_left--;
                if (!ha || m_left == 0) m_phase = P_IDLE;
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = P_IDLE; m_fails = 0;
                end
            end
        endcase
    endtask

    task automatic drive(input bit r, input bit ha, input bit pv, input logic [3:0] pin);
        @(negedge clk);
        rst           = r;
        bus.HasAccess = ha;
        bus.pin_valid = pv;
        bus.Input_Pin = pin;
        model_step(r, ha, pv, pin);
        exp_q.push_back(model_view());
    endtask

    task automatic hold(input int n, input bit ha);
        for (int i = 0; i < n; i++) drive(1'b0, ha, 1'b0, 4'b0000);
    endtask

    // Monitor: one expected observation per clock edge after stimulus begins.
    initial begin
        obs_t act, exp;
        @(negedge clk);
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            act = '{bus.pin_ready, bus.message, bus.Welcome, bus.locked, bus.fail_count};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow cycle=%0d no expected entry", cyc);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d got ready=%b msg=%b welcome=%b locked=%b fails=%0d expected ready=%b msg=%b welcome=%b locked=%b fails=%0d",
                             cyc, act.ready, act.msg, act.welcome, act.locked, act.fails,
                             exp.ready, exp.msg, exp.welcome, exp.locked, exp.fails);
                end
            end
        end
    end

    initial begin
        bus.HasAccess = 1'b0;
        bus.pin_valid = 1'b0;
        bus.Input_Pin = 4'b0000;

        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        drive(1'b1, 1'b1, 1'b1, PIN_OK);
        hold(2, 1'b0);

        // Correct PIN, then hold HasAccess past the grant window.
        hold(2, 1'b1);
        drive(1'b0, 1'b1, 1'b1, PIN_OK);
        hold(12, 1'b1);
        hold(3, 1'b0);

        // Three wrong PINs to lockout, correct PIN ignored while locked.
        hold(2, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 4'b0101);
        hold(1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 4'b0101);
        drive(1'b0, 1'b1, 1'b1, 4'b0101);
        drive(1'b0, 1'b1, 1'b1, PIN_OK);
        drive(1'b0, 1'b0, 1'b1, PIN_OK);
        hold(16, 1'b1);
        hold(2, 1'b0);

        // One wrong PIN, then a timeout with no further attempts.
        hold(2, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 4'b0011);
        hold(36, 1'b1);
        hold(2, 1'b0);

        // Persistence across an abandoned session.
        hold(2, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 4'b0000);
        hold(2, 1'b0);
        hold(2, 1'b1);
        drive(1'b0, 1'b1, 1'b1, PIN_OK);
        hold(3, 1'b1);
        hold(2, 1'b0);

        // HasAccess drops in the same cycle as a correct PIN.
        hold(2, 1'b1);
        drive(1'b0, 1'b0, 1'b1, PIN_OK);
        hold(2, 1'b0);

        // Reset asserted during the third Welcome cycle.
        hold(2, 1'b1);
        drive(1'b0, 1'b1, 1'b1, PIN_OK);
        hold(2, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 4'b0000);
        hold(3, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            bit r, ha, pv;
            logic [3:0] pin;
            r   = ($urandom_range(0, 199) == 0);
            ha  = ($urandom_range(0, 99) < 88);
            pv  = ($urandom_range(0, 99) < 30);
            pin = ($urandom_range(0, 3) == 0) ? PIN_OK : 4'($urandom_range(0, 15));
            drive(r, ha, pv, pin);
        end
        hold(2, 1'b0);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
